// File: rtl/debounce_edge_bank_pkg.sv
// Shared types and timing constants for the push-button/switch debouncer bank.
// Parameter defaults are expressed in milliseconds of the 50 MHz system clock.
package debounce_edge_bank_pkg;

   localparam int CLK_HZ     = 50_000_000;
   localparam int CYC_PER_MS = CLK_HZ / 1000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2,
      ST_RPT  = 2'd3
   } rpt_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop synchroniser, stability counter, edge pulses and
// auto-repeat press generator. Input is already polarity-normalised (1 = active).
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | debounced level low, waiting for a rise
//   ST_WAIT | level high, auto-repeat disabled until the next rise
//   ST_HOLD | level high, timing the initial hold before the first repeat
//   ST_RPT  | level high, emitting a press every REPEAT_CYCLES
module debounce_channel
   import debounce_edge_bank_pkg::*;
#(
   parameter int DB_CYCLES     = 30 * CYC_PER_MS,
   parameter int HOLD_CYCLES   = 500 * CYC_PER_MS,
   parameter int REPEAT_CYCLES = 100 * CYC_PER_MS
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_x,
   input  logic i_repeat_en,
   output logic o_y,
   output logic o_rise,
   output logic o_fall,
   output logic o_press
);

   localparam int CW = $clog2(DB_CYCLES + 1);
   localparam int TW = $clog2(max_int(HOLD_CYCLES, REPEAT_CYCLES) + 1);
   localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYCLES - 1);
   localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] RPT_LAST  = TW'(REPEAT_CYCLES - 1);

   logic          r_s1;
   logic          r_xs;
   logic          r_y;
   logic          r_rise;
   logic          r_fall;
   logic          r_press;
   logic [CW-1:0] r_cnt;
   logic [TW-1:0] r_tmr;
   rpt_state_t    r_state;

   logic          w_done;
   logic          w_rise_evt;
   logic          w_fall_evt;
   logic          w_press_nxt;
   logic [TW-1:0] w_tmr_nxt;
   rpt_state_t    w_state_nxt;

   // The repeat FSM reacts to the edge that toggles y, so press lines up with rise.
   assign w_done     = (r_xs != r_y) && (r_cnt == DB_LAST);
   assign w_rise_evt = w_done && !r_y;
   assign w_fall_evt = w_done && r_y;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_s1   <= 1'b0;
         r_xs   <= 1'b0;
         r_y    <= 1'b0;
         r_cnt  <= '0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_s1   <= i_x;
         r_xs   <= r_s1;
         r_rise <= w_rise_evt;
         r_fall <= w_fall_evt;
         if (r_xs == r_y) begin
            r_cnt <= '0;
         end else if (r_cnt == DB_LAST) begin
            r_cnt <= '0;
            r_y   <= ~r_y;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_tmr   <= '0;
         r_press <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_tmr   <= w_tmr_nxt;
         r_press <= w_press_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tmr_nxt   = r_tmr;
      w_press_nxt = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_rise_evt) begin
               w_press_nxt = 1'b1;
               w_tmr_nxt   = '0;
               w_state_nxt = i_repeat_en ? ST_HOLD : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (w_fall_evt) w_state_nxt = ST_IDLE;
         end
         ST_HOLD: begin
            if (w_fall_evt) begin
               w_state_nxt = ST_IDLE;
            end else if (!i_repeat_en) begin
               w_state_nxt = ST_WAIT;
            end else if (r_tmr == HOLD_LAST) begin
               w_press_nxt = 1'b1;
               w_tmr_nxt   = '0;
               w_state_nxt = ST_RPT;
            end else begin
               w_tmr_nxt = r_tmr + TW'(1);
            end
         end
         ST_RPT: begin
            if (w_fall_evt) begin
               w_state_nxt = ST_IDLE;
            end else if (!i_repeat_en) begin
               w_state_nxt = ST_WAIT;
            end else if (r_tmr == RPT_LAST) begin
               w_press_nxt = 1'b1;
               w_tmr_nxt   = '0;
            end else begin
               w_tmr_nxt = r_tmr + TW'(1);
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign o_y     = r_y;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;
   assign o_press = r_press;

endmodule

// File: rtl/debounce_edge_bank.sv
// N-channel debouncer bank for KEY/SW pins: normalises polarity and fans each
// input bit out to an independent debounce_channel.
module debounce_edge_bank
   import debounce_edge_bank_pkg::*;
#(
   parameter int N             = 4,
   parameter int DB_CYCLES     = 30 * CYC_PER_MS,
   parameter int HOLD_CYCLES   = 500 * CYC_PER_MS,
   parameter int REPEAT_CYCLES = 100 * CYC_PER_MS,
   parameter bit ACTIVE_LOW    = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] x,
   input  logic [N-1:0] repeat_en,
   output logic [N-1:0] y,
   output logic [N-1:0] rise,
   output logic [N-1:0] fall,
   output logic [N-1:0] press
);

   logic [N-1:0] w_xn;

   assign w_xn = ACTIVE_LOW ? ~x : x;

   for (genvar g = 0; g < N; g++) begin : g_ch
      debounce_channel #(
         .DB_CYCLES    (DB_CYCLES),
         .HOLD_CYCLES  (HOLD_CYCLES),
         .REPEAT_CYCLES(REPEAT_CYCLES)
      ) u_ch (
         .i_clk      (clk),
         .i_reset    (reset),
         .i_x        (w_xn[g]),
         .i_repeat_en(repeat_en[g]),
         .o_y        (y[g]),
         .o_rise     (rise[g]),
         .o_fall     (fall[g]),
         .o_press    (press[g])
      );
   end

endmodule

// File: tb/tb_debounce_edge_bank.sv
// Scoreboard bench: driver pushes reference-model expectations, monitor pops and
// compares both an active-high and an active-low instance every cycle.
module tb_debounce_edge_bank;

   localparam int N    = 2;
   localparam int DB   = 4;
   localparam int HOLD = 10;
   localparam int RPT  = 3;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] x = '0;
   logic [N-1:0] ren = '0;
   logic [N-1:0] y_a, rise_a, fall_a, press_a;
   logic [N-1:0] y_b, rise_b, fall_b, press_b;

   typedef struct packed {
      logic [1:0] y;
      logic [1:0] rise;
      logic [1:0] fall;
      logic [1:0] press;
   } obs_t;

   typedef struct packed {
      obs_t a;
      obs_t b;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   // Reference state, index = dut*2 + channel (dut 0 active-high, dut 1 active-low)
   bit h1[4];
   bit h2[4];
   bit my[4];
   bit rep_ok[4];
   int run[4];
   int held[4];

   always #5 clk = ~clk;

   debounce_edge_bank #(
      .N(N), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(RPT), .ACTIVE_LOW(1'b0)
   ) u_dut_a (
      .clk(clk), .reset(reset), .x(x), .repeat_en(ren),
      .y(y_a), .rise(rise_a), .fall(fall_a), .press(press_a)
   );

   debounce_edge_bank #(
      .N(N), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(RPT), .ACTIVE_LOW(1'b1)
   ) u_dut_b (
      .clk(clk), .reset(reset), .x(x), .repeat_en(ren),
      .y(y_b), .rise(rise_b), .fall(fall_b), .press(press_b)
   );

   // Behavioural rules: y flips on the DB-th consecutive edge where the input seen
   // two edges earlier disagrees with y; press on each rise, then (if repeat_en stayed
   // high all along) when time-since-rise t satisfies t >= HOLD and (t-HOLD) % RPT == 0.
   task automatic step(input logic [1:0] xv, input logic [1:0] rv, input bit rst);
      obs_t o[2];
      exp_t e;
      @(negedge clk);
      x     = xv;
      ren   = rv;
      reset = rst;
      for (int d = 0; d < 2; d++) begin
         o[d] = '0;
         for (int c = 0; c < 2; c++) begin
            int i;
            bit xn, xs, r, f, p;
            i  = d * 2 + c;
            xn = (d == 1) ? ~xv[c] : xv[c];
            r  = 1'b0;
            f  = 1'b0;
            p  = 1'b0;
            if (rst) begin
               h1[i] = 0; h2[i] = 0; my[i] = 0; rep_ok[i] = 0; run[i] = 0; held[i] = 0;
            end else begin
               xs    = h2[i];
               h2[i] = h1[i];
               h1[i] = xn;
               if (xs != my[i]) begin
                  run[i]++;
                  if (run[i] == DB) begin
                     my[i]  = !my[i];
                     run[i] = 0;
                     r      = my[i];
                     f      = !my[i];
                  end
               end else begin
                  run[i] = 0;
               end
               if (r) begin
                  p         = 1'b1;
                  held[i]   = 0;
                  rep_ok[i] = rv[c];
               end else if (my[i]) begin
                  held[i]++;
                  rep_ok[i] = rep_ok[i] & rv[c];
                  if (rep_ok[i] && held[i] >= HOLD && ((held[i] - HOLD) % RPT) == 0) p = 1'b1;
               end
            end
            o[d].y[c]     = my[i];
            o[d].rise[c]  = r;
            o[d].fall[c]  = f;
            o[d].press[c] = p;
         end
      end
      e.a = o[0];
      e.b = o[1];
      q.push_back(e);
   endtask

   always @(posedge clk) begin
      #1;
      cyc++;
      if (q.size() > 0) begin
         mon_e = q.pop_front();
         checks++;
         if ({y_a, rise_a, fall_a, press_a} !== mon_e.a) begin
            errors++;
            $display("FAIL dut_a cycle %0d got y=%b rise=%b fall=%b press=%b expected y=%b rise=%b fall=%b press=%b",
                     cyc, y_a, rise_a, fall_a, press_a, mon_e.a.y, mon_e.a.rise, mon_e.a.fall, mon_e.a.press);
         end
         checks++;
         if ({y_b, rise_b, fall_b, press_b} !== mon_e.b) begin
            errors++;
            $display("FAIL dut_b cycle %0d got y=%b rise=%b fall=%b press=%b expected y=%b rise=%b fall=%b press=%b",
                     cyc, y_b, rise_b, fall_b, press_b, mon_e.b.y, mon_e.b.rise, mon_e.b.fall, mon_e.b.press);
         end
      end
   end

   initial begin
      logic [1:0] xv;
      logic [1:0] rv;
      bit         rst;
      int         len;

      // Reset, idle inputs, then reset held while x[0] is active
      repeat (3)  step(2'b00, 2'b00, 1'b1);
      repeat (20) step(2'b00, 2'b00, 1'b0);
      repeat (30) step(2'b01, 2'b00, 1'b1);
      repeat (2)  step(2'b00, 2'b00, 1'b1);
      repeat (12) step(2'b00, 2'b00, 1'b0);

      // Clean press and release
      repeat (12) step(2'b01, 2'b00, 1'b0);
      repeat (12) step(2'b00, 2'b00, 1'b0);

      // Short glitch, then a bounce 1,0,1,1,1,1,1 and hold
      repeat (3)  step(2'b01, 2'b00, 1'b0);
      repeat (10) step(2'b00, 2'b00, 1'b0);
      step(2'b01, 2'b00, 1'b0);
      step(2'b00, 2'b00, 1'b0);
      repeat (13) step(2'b01, 2'b00, 1'b0);
      repeat (12) step(2'b00, 2'b00, 1'b0);

      // Auto-repeat while held, then release
      repeat (30) step(2'b01, 2'b01, 1'b0);
      repeat (12) step(2'b00, 2'b01, 1'b0);

      // No repeat when disabled; drop repeat_en during HOLD and re-raise in WAIT
      repeat (20) step(2'b01, 2'b00, 1'b0);
      repeat (12) step(2'b00, 2'b00, 1'b0);
      repeat (9)  step(2'b01, 2'b01, 1'b0);
      repeat (20) step(2'b01, 2'b00, 1'b0);
      repeat (20) step(2'b01, 2'b01, 1'b0);
      repeat (12) step(2'b00, 2'b01, 1'b0);

      // Simultaneous events on both channels, with a repeat on channel 1 only
      repeat (30) step(2'b11, 2'b10, 1'b0);
      repeat (12) step(2'b00, 2'b10, 1'b0);

      // Fresh reset with x=2'b10: active-low instance sees channel 0 pressed
      repeat (2)  step(2'b10, 2'b00, 1'b1);
      repeat (15) step(2'b10, 2'b00, 1'b0);

      // Randomised segments
      rv = 2'b00;
      for (int seg = 0; seg < 250; seg++) begin
         xv = 2'($urandom);
         if ($urandom_range(0, 3) == 0) rv = 2'($urandom);
         rst = ($urandom_range(0, 60) == 0);
         if (rst) len = 2;
         else if ($urandom_range(0, 4) == 0) len = $urandom_range(15, 40);
         else len = $urandom_range(1, 14);
         repeat (len) step(xv, rv, rst);
      end

      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
